// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the multiplexed seven-segment scanner.
// Glyphs are active-low cathode patterns ordered {g,f,e,d,c,b,a}.
package seven_seg_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int IDX_W      = 2;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [3:0]       bcd_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seven_seg_scan_if.sv
// Digit inputs from the BCD converter and active-low display outputs.
// The scanner is the slave; whoever feeds digits and watches the display is the master.
interface seven_seg_scan_if;
  import seven_seg_pkg::*;

  bcd_t       D4;
  bcd_t       hundreds;
  bcd_t       tens;
  bcd_t       ones;
  logic       blank_lz;
  logic [3:0] dp_en;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame;

  modport master (
    output D4, hundreds, tens, ones, blank_lz, dp_en,
    input  an, seg, dp, frame
  );

  modport slave (
    input  D4, hundreds, tens, ones, blank_lz, dp_en,
    output an, seg, dp, frame
  );

endinterface

// File: rtl/seven_seg_scan_bcd_to_seg.sv
// Combinational BCD-to-glyph decoder; non-decimal codes render as a dash.
module bcd_to_seg
  import seven_seg_pkg::*;
(
  input  bcd_t       value,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (value)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Round-robin 4-digit scanner with per-frame input snapshot, leading-zero
// blanking and an all-anodes-off guard at the start of every digit slot.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 16
) (
  input  logic              clk,
  input  logic              rst,
  seven_seg_scan_if.slave   bus
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);
  localparam idx_t             IDX_LAST  = idx_t'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt;
  idx_t             idx;
  logic             slot_end;
  logic             load;

  logic [NUM_DIGITS-1:0][3:0] shadow_digit;
  logic                       shadow_blz;
  logic [NUM_DIGITS-1:0]      shadow_dp;
  logic [NUM_DIGITS-1:0]      blank;

  bcd_t       cur_digit;
  logic       cur_blank;
  logic [6:0] seg_next;

  logic [3:0] an_q;
  logic [6:0] seg_q;
  logic       dp_q;
  logic       frame_q;

  assign slot_end = (cnt == CNT_LAST);
  assign load     = slot_end && (idx == IDX_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= idx + idx_t'(1);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Inputs are captured only at the end of the last slot so a frame never tears.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_digit <= '0;
      shadow_blz   <= 1'b0;
      shadow_dp    <= '0;
    end else if (load) begin
      shadow_digit <= {bus.D4, bus.hundreds, bus.tens, bus.ones};
      shadow_blz   <= bus.blank_lz;
      shadow_dp    <= bus.dp_en;
    end
  end

  // A digit is a leading zero only if every digit to its left is also blanked.
  always_comb begin
    blank    = '0;
    blank[3] = shadow_blz && (shadow_digit[3] == 4'd0);
    blank[2] = blank[3] && (shadow_digit[2] == 4'd0);
    blank[1] = blank[2] && (shadow_digit[1] == 4'd0);
  end

  assign cur_digit = shadow_digit[idx];
  assign cur_blank = blank[idx];

  bcd_to_seg u_dec (
    .value (cur_digit),
    .blank (cur_blank),
    .seg   (seg_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      an_q    <= 4'b1111;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      an_q    <= (cnt < CNT_GUARD) ? 4'b1111 : ~(4'b0001 << idx);
      seg_q   <= seg_next;
      dp_q    <= ~shadow_dp[idx];
      frame_q <= load;
    end
  end

  assign bus.an    = an_q;
  assign bus.seg   = seg_q;
  assign bus.dp    = dp_q;
  assign bus.frame = frame_q;

endmodule
